// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake and one-entry skid.
// Optional stall counter: define PIPE_STAGE_SKID_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RST_DATA = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {m_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              skid_valid;

  assign m_valid    = state_q[1];
  assign skid_valid = state_q[0];
  assign s_ready    = ~skid_valid;
  assign m_data     = main_q;

  // Next state and payload moves; flush squashes everything held.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_DATA;
      skid_d  = RST_DATA;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (s_valid) begin
            main_d  = s_data;
            state_d = FULL;
          end
        end
        FULL: begin
          if (m_ready && s_valid) begin
            main_d = s_data;
          end else if (m_ready) begin
            main_d  = RST_DATA;
            state_d = EMPTY;
          end else if (s_valid) begin
            skid_d  = s_data;
            state_d = SKID;
          end
        end
        SKID: begin
          if (m_ready) begin
            main_d  = skid_q;
            skid_d  = RST_DATA;
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RST_DATA;
          skid_d  = RST_DATA;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_DATA;
      skid_q  <= RST_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // A held skid entry without a valid main entry would break ordering.
  a_no_orphan_skid: assert property (
    @(posedge clk) disable iff (rst) !(!m_valid && skid_valid)
  );

`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of cycles the downstream stage refuses a payload.
  always_comb begin
    cnt_d = cnt_q;
    if (!flush && m_valid && !m_ready &&
        cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios plus
// randomized stress against a depth-2 FIFO reference model.
module tb_pipe_stage_skid;

  localparam int unsigned DW   = 32;
  localparam logic [31:0] RSTD = 32'hDEAD0000;
  localparam int unsigned CW   = 4;
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] stall_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  pipe_stage_skid #(
    .DATA_W  (DW),
    .RST_DATA(RSTD),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
    tick(); tick();
    total_cnt++;
    if (m_valid !== 1'b0)
      $display("FAIL reset_m_valid got %b want 0", m_valid);
    else pass_cnt++;
    total_cnt++;
    if (m_data !== RSTD)
      $display("FAIL reset_m_data got %h want %h", m_data, RSTD);
    else pass_cnt++;
    total_cnt++;
    if (s_ready !== 1'b1)
      $display("FAIL reset_s_ready got %b want 1", s_ready);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 4'd0)
      $display("FAIL reset_stall got %0d want 0", stall_cnt);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    m_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1; s_data = i;
      tick();
      exp = i;
      total_cnt++;
      if ({m_valid, s_ready, m_data} !== {2'b11, exp})
        $display("FAIL stream_%0d got v=%b r=%b d=%h want v=1 r=1 d=%h",
                 i, m_valid, s_ready, m_data, exp);
      else pass_cnt++;
    end
    s_valid = 1'b0;
    tick();
    total_cnt++;
    if ({m_valid, m_data} !== {1'b0, RSTD})
      $display("FAIL stream_bubble got v=%b d=%h want v=0 d=%h",
               m_valid, m_data, RSTD);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hA;
    tick();
    total_cnt++;
    if ({m_valid, s_ready, m_data} !== {2'b11, 32'hA})
      $display("FAIL bp_loadA got v=%b r=%b d=%h want v=1 r=1 d=a",
               m_valid, s_ready, m_data);
    else pass_cnt++;
    s_data = 32'hB;
    tick();
    s_valid = 1'b0;
    total_cnt++;
    if ({s_ready, m_data} !== {1'b0, 32'hA})
      $display("FAIL bp_skid got r=%b d=%h want r=0 d=a", s_ready, m_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({m_valid, s_ready, m_data} !== {2'b10, 32'hA})
      $display("FAIL bp_hold got v=%b r=%b d=%h want v=1 r=0 d=a",
               m_valid, s_ready, m_data);
    else pass_cnt++;
    m_ready = 1'b1;
    tick();
    total_cnt++;
    if ({m_valid, s_ready, m_data} !== {2'b11, 32'hB})
      $display("FAIL bp_drainB got v=%b r=%b d=%h want v=1 r=1 d=b",
               m_valid, s_ready, m_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({m_valid, s_ready, m_data} !== {2'b01, RSTD})
      $display("FAIL bp_empty got v=%b r=%b d=%h want v=0 r=1 d=%h",
               m_valid, s_ready, m_data, RSTD);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h5;
    tick();
    s_data = 32'h6;
    tick();
    total_cnt++;
    if (s_ready !== 1'b0)
      $display("FAIL flush_setup got r=%b want 0", s_ready);
    else pass_cnt++;
    flush = 1'b1; s_data = 32'h7;
    tick();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    total_cnt++;
    if ({m_valid, s_ready, m_data} !== {2'b01, RSTD})
      $display("FAIL flush_clear got v=%b r=%b d=%h want v=0 r=1 d=%h",
               m_valid, s_ready, m_data, RSTD);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if ({m_valid, m_data} !== {1'b0, RSTD})
        $display("FAIL flush_leak_%0d got v=%b d=%h want v=0 d=%h",
                 i, m_valid, m_data, RSTD);
      else pass_cnt++;
    end
  endtask

  task automatic test_rst_flush();
    logic [3:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h11;
    tick();
    s_valid = 1'b0;
    tick(); tick(); tick();
    exp = CNT_ON ? 4'd3 : 4'd0;
    total_cnt++;
    if (stall_cnt !== exp)
      $display("FAIL stall3 got %0d want %0d", stall_cnt, exp);
    else pass_cnt++;
    flush = 1'b1; m_ready = 1'b1;
    tick();
    flush = 1'b0;
    total_cnt++;
    if ({m_valid, stall_cnt} !== {1'b0, exp})
      $display("FAIL flush_keep_cnt got v=%b c=%0d want v=0 c=%0d",
               m_valid, stall_cnt, exp);
    else pass_cnt++;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h22;
    tick();
    s_valid = 1'b1; s_data = 32'h33;
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    total_cnt++;
    if ({m_valid, s_ready, m_data, stall_cnt} !== {2'b01, RSTD, 4'd0})
      $display("FAIL rst_flush got v=%b r=%b d=%h c=%0d want v=0 r=1 d=%h c=0",
               m_valid, s_ready, m_data, stall_cnt, RSTD);
    else pass_cnt++;
  endtask

  task automatic test_stall_sat();
    logic [3:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hC0FFEE;
    tick();
    s_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = CNT_ON ? 4'(sat(k)) : 4'd0;
      total_cnt++;
      if ({m_valid, m_data, stall_cnt} !== {1'b1, 32'hC0FFEE, exp})
        $display("FAIL stall_sat_%0d got v=%b d=%h c=%0d want v=1 d=c0ffee c=%0d",
                 k, m_valid, m_data, stall_cnt, exp);
      else pass_cnt++;
    end
    m_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int          sc;
    logic [31:0] exp_d;
    logic [3:0]  exp_c;
    bit          full_in;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    tick();
    rst = 1'b0;
    sc = 0;
    for (int c = 0; c < 10000; c++) begin
      exp_d = (q.size() > 0) ? q[0] : RSTD;
      exp_c = CNT_ON ? 4'(sc) : 4'd0;
      total_cnt++;
      if ({m_valid, s_ready, m_data, stall_cnt} !==
          {q.size() > 0, q.size() < 2, exp_d, exp_c})
        $display("FAIL rand_c%0d got v=%b r=%b d=%h c=%0d want v=%b r=%b d=%h c=%0d",
                 c, m_valid, s_ready, m_data, stall_cnt,
                 q.size() > 0, q.size() < 2, exp_d, exp_c);
      else pass_cnt++;
      s_valid = ($urandom_range(0, 99) < 60);
      m_ready = ($urandom_range(0, 99) < 55);
      s_data  = $urandom;
      flush   = ($urandom_range(0, 63) == 0);
      if (flush) m_ready = 1'b1;
      full_in = (q.size() >= 2);
      if (q.size() > 0 && !m_ready) sc = sat(sc + 1);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && m_ready) void'(q.pop_front());
        if (s_valid && !full_in) q.push_back(s_data);
      end
      tick();
    end
    flush = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_rst_flush();
    test_stall_sat();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
